// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction byte prefetch queue fetching 16-bit words from cs:ip
module prefetch_queue #(
   parameter int DEPTH = 6
) (
   input  logic        clock,
   input  logic        locked,
   output logic [19:0] o_addr,
   output logic        o_rd,
   input  logic        m_ready,
   input  logic [15:0] i_data,
   input  logic        flush,
   input  logic [15:0] i_cs,
   input  logic [15:0] i_ip,
   output logic        q_valid,
   output logic [7:0]  q_byte,
   output logic [15:0] q_ip,
   input  logic        q_take
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    mem [DEPTH];
   logic [7:0]    nxt [DEPTH];
   logic [CW-1:0] count, rem, count_next;
   logic [15:0]   cs, fetch_ip;
   logic [1:0]    push_n;
   logic [7:0]    b0, b1;
   logic          fetch, pop;

   assign o_rd       = fetch_ip[0] ? (count <= CW'(DEPTH - 1)) : (count <= CW'(DEPTH - 2));
   assign o_addr     = {cs, 4'h0} + {4'h0, fetch_ip[15:1], 1'b0};
   assign q_valid    = count != '0;
   assign q_byte     = mem[0];
   assign fetch      = o_rd & m_ready;
   assign pop        = q_valid & q_take;
   assign rem        = count - CW'(pop);
   assign push_n     = fetch ? (fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
   assign count_next = rem + CW'(push_n);
   assign b0         = fetch_ip[0] ? i_data[15:8] : i_data[7:0];
   assign b1         = i_data[15:8];

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      localparam logic [CW-1:0] K = CW'(g);
      assign nxt[g] = (K < rem) ? (pop ? mem[(g + 1) % DEPTH] : mem[g]) : (K == rem) ? b0 : b1;
   end

   // byte storage: shift out the head on pop, append fetched bytes behind the survivors
   always_ff @(posedge clock) begin
      mem <= nxt;
   end

   // queue bookkeeping: flush restarts at i_cs:i_ip and overrides push and pop
   always_ff @(posedge clock or negedge locked) begin
      if (!locked) begin
         count    <= '0;
         cs       <= '0;
         fetch_ip <= '0;
         q_ip     <= '0;
      end else if (flush) begin
         count    <= '0;
         cs       <= i_cs;
         fetch_ip <= i_ip;
         q_ip     <= i_ip;
      end else begin
         count <= count_next;
         if (fetch) fetch_ip <= fetch_ip + (fetch_ip[0] ? 16'd1 : 16'd2);
         if (pop) q_ip <= q_ip + 16'd1;
      end
   end
endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed self-checking bench for prefetch_queue
module tb_prefetch_queue;
   logic        clock = 1'b0;
   logic        locked, m_ready, flush, q_take, o_rd, q_valid;
   logic [15:0] i_data, i_cs, i_ip, q_ip;
   logic [19:0] o_addr;
   logic [7:0]  q_byte;
   int errors = 0;
   int checks = 0;

   prefetch_queue #(.DEPTH(6)) dut (
      .clock(clock), .locked(locked), .o_addr(o_addr), .o_rd(o_rd), .m_ready(m_ready),
      .i_data(i_data), .flush(flush), .i_cs(i_cs), .i_ip(i_ip), .q_valid(q_valid),
      .q_byte(q_byte), .q_ip(q_ip), .q_take(q_take)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [15:0] d, input logic tk, input logic fl);
      m_ready = rdy;
      i_data  = d;
      q_take  = tk;
      flush   = fl;
   endtask

   initial begin
      locked = 1'b0;
      i_cs   = 16'h0;
      i_ip   = 16'h0;
      drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
      #2;
      chk("rst_qvalid", 32'(q_valid), 32'h0);
      chk("rst_ord", 32'(o_rd), 32'h1);
      chk("rst_addr", 32'(o_addr), 32'h0);
      chk("rst_qip", 32'(q_ip), 32'h0);
      step();
      step();
      chk("rst_hold_qvalid", 32'(q_valid), 32'h0);
      chk("rst_hold_addr", 32'(o_addr), 32'h0);
      locked = 1'b1;
      drive(1'b1, 16'hB890, 1'b0, 1'b0);
      step();
      chk("f1_qvalid", 32'(q_valid), 32'h1);
      chk("f1_byte", 32'(q_byte), 32'h90);
      chk("f1_qip", 32'(q_ip), 32'h0);
      chk("f1_addr", 32'(o_addr), 32'h00002);
      drive(1'b1, 16'h0000, 1'b1, 1'b0);
      step();
      chk("f2_byte", 32'(q_byte), 32'hB8);
      chk("f2_qip", 32'(q_ip), 32'h1);
      chk("f2_addr", 32'(o_addr), 32'h00004);
      i_cs = 16'h1234;
      i_ip = 16'h0005;
      drive(1'b1, 16'h7777, 1'b1, 1'b1);
      step();
      chk("fl_qvalid", 32'(q_valid), 32'h0);
      chk("fl_qip", 32'(q_ip), 32'h0005);
      chk("fl_addr", 32'(o_addr), 32'h12344);
      chk("fl_ord", 32'(o_rd), 32'h1);
      drive(1'b1, 16'hABCD, 1'b0, 1'b0);
      step();
      chk("odd_byte", 32'(q_byte), 32'hAB);
      chk("odd_qip", 32'(q_ip), 32'h0005);
      chk("odd_addr", 32'(o_addr), 32'h12346);
      drive(1'b1, 16'h2211, 1'b1, 1'b0);
      step();
      chk("pp_qvalid", 32'(q_valid), 32'h1);
      chk("pp_byte", 32'(q_byte), 32'h11);
      chk("pp_qip", 32'(q_ip), 32'h0006);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
      chk("pp2_byte", 32'(q_byte), 32'h22);
      chk("pp2_qip", 32'(q_ip), 32'h0007);
      step();
      chk("pp3_qvalid", 32'(q_valid), 32'h0);
      chk("pp3_qip", 32'(q_ip), 32'h0008);
      step();
      chk("empty_take_qip", 32'(q_ip), 32'h0008);
      i_cs = 16'h0000;
      i_ip = 16'h0000;
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      step();
      drive(1'b1, 16'h0201, 1'b0, 1'b0);
      step();
      i_data = 16'h0403;
      step();
      i_data = 16'h0605;
      step();
      chk("full_ord", 32'(o_rd), 32'h0);
      chk("full_addr", 32'(o_addr), 32'h00006);
      i_data = 16'h0807;
      step();
      chk("full_hold_ord", 32'(o_rd), 32'h0);
      chk("full_hold_byte", 32'(q_byte), 32'h01);
      chk("full_hold_addr", 32'(o_addr), 32'h00006);
      drive(1'b1, 16'h0807, 1'b1, 1'b0);
      step();
      chk("c5_ord", 32'(o_rd), 32'h0);
      chk("c5_byte", 32'(q_byte), 32'h02);
      chk("c5_qip", 32'(q_ip), 32'h0001);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
      chk("c4_ord", 32'(o_rd), 32'h1);
      chk("c4_byte", 32'(q_byte), 32'h03);
      step();
      chk("d3_byte", 32'(q_byte), 32'h04);
      step();
      chk("d2_byte", 32'(q_byte), 32'h05);
      step();
      chk("d1_byte", 32'(q_byte), 32'h06);
      step();
      chk("d0_qvalid", 32'(q_valid), 32'h0);
      chk("d0_qip", 32'(q_ip), 32'h0006);
      i_cs = 16'hF000;
      i_ip = 16'hFFFE;
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      step();
      chk("w_addr0", 32'(o_addr), 32'hFFFFE);
      drive(1'b1, 16'h3231, 1'b0, 1'b0);
      step();
      chk("w_addr1", 32'(o_addr), 32'hF0000);
      chk("w_byte1", 32'(q_byte), 32'h31);
      chk("w_qip1", 32'(q_ip), 32'hFFFE);
      drive(1'b1, 16'h3433, 1'b1, 1'b0);
      step();
      chk("w_addr2", 32'(o_addr), 32'hF0002);
      chk("w_byte2", 32'(q_byte), 32'h32);
      chk("w_qip2", 32'(q_ip), 32'hFFFF);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
      chk("w_byte3", 32'(q_byte), 32'h33);
      chk("w_qip3", 32'(q_ip), 32'h0000);
      drive(1'b1, 16'h5555, 1'b0, 1'b0);
      locked = 1'b0;
      #1;
      chk("ar_qvalid", 32'(q_valid), 32'h0);
      chk("ar_ord", 32'(o_rd), 32'h1);
      chk("ar_addr", 32'(o_addr), 32'h0);
      chk("ar_qip", 32'(q_ip), 32'h0);
      step();
      chk("ar_hold_qvalid", 32'(q_valid), 32'h0);
      locked = 1'b1;
      drive(1'b1, 16'hB890, 1'b0, 1'b0);
      step();
      chk("rel_byte", 32'(q_byte), 32'h90);
      chk("rel_qvalid", 32'(q_valid), 32'h1);
      chk("rel_addr", 32'(o_addr), 32'h00002);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 6, meaning queue capacity in bytes (even, 4..14).
REQ-002 The block SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port locked  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port o_addr  output  20  word-aligned physical fetch address: ({cs,4'h0} + {fetch_ip[15:1],1'b0}) mod 2^20, bit 0 always 0.
REQ-005 The block SHALL have port o_rd  output  1  fetch request, combinational from registered state.
REQ-006 The block SHALL have port m_ready  input  1  memory word valid on i_data this cycle; ignored when o_rd=0.
REQ-007 The block SHALL have port i_data  input  16  memory word; low byte = even address.
REQ-008 The block SHALL have port flush  input  1  discard queue, restart fetch at i_cs:i_ip.
REQ-009 The block SHALL have ports i_cs, i_ip  input  16 each  new code segment / offset, sampled when flush=1.
REQ-010 The block SHALL have port q_valid  output  1  head byte available (count != 0).
REQ-011 The block SHALL have port q_byte  output  8  head byte; don't-care when q_valid=0.
REQ-012 The block SHALL have port q_ip  output  16  offset of head byte (next IP to be consumed by the decoder).
REQ-013 The block SHALL have port q_take  input  1  consume head byte this cycle; ignored when q_valid=0.

Function
REQ-014 State SHALL be: byte FIFO storage[DEPTH], count (0..DEPTH), cs, fetch_ip, q_ip; no other FSM states.
REQ-015 o_rd SHALL be 1 when (fetch_ip[0]=0 and count <= DEPTH-2) or (fetch_ip[0]=1 and count <= DEPTH-1), else 0.
REQ-016 A fetch completes on a cycle with o_rd=1 and m_ready=1; o_addr SHALL stay stable while o_rd=1 and m_ready=0 (q_take never changes o_addr or drops o_rd).
REQ-017 Fetch with fetch_ip even: push i_data[7:0] then i_data[15:8] (2 bytes); fetch_ip += 2.
REQ-018 Fetch with fetch_ip odd: push i_data[15:8] only (1 byte); fetch_ip += 1 (realigns to even).
REQ-019 fetch_ip and q_ip SHALL wrap modulo 2^16 (segment wrap); o_addr sum wraps modulo 2^20.
REQ-020 Accepted q_take: pop head, q_ip += 1; bytes behind shift toward head in order.
REQ-021 Push and pop in same cycle: count_next = count + pushed - 1; popped byte is the old head; pushed bytes are appended after remaining bytes.
REQ-022 Pop of the only byte with simultaneous push: new head SHALL be first pushed byte, q_valid stays 1.
REQ-023 flush=1 SHALL take priority over push and pop: count<=0, cs<=i_cs, fetch_ip<=i_ip, q_ip<=i_ip; m_ready data in that cycle discarded, q_take ignored.
REQ-024 After flush, o_addr SHALL reflect new cs/fetch_ip on the next cycle; first byte earliest q_valid one cycle after the first accepted m_ready.
REQ-025 Push latency: byte delivered by m_ready at edge N SHALL be visible on q_byte (if at head) after edge N, no extra cycles.
REQ-026 Count SHALL never exceed DEPTH; the o_rd rule of REQ-015 guarantees space, no overflow path exists.
REQ-027 No output SHALL depend combinationally on m_ready, q_take or flush.

Reset
REQ-028 locked=0 SHALL asynchronously set count=0, cs=16'h0000, fetch_ip=16'h0000, q_ip=16'h0000, storage contents don't-care.
REQ-029 During and after reset: q_valid=0, o_rd=1, o_addr=20'h00000 (start at 0000:0000).
REQ-030 Reset mid-fetch SHALL abandon the request; a m_ready arriving while locked=0 SHALL be ignored.
REQ-031 First clock edge after locked rises SHALL behave as a normal cycle (no extra warm-up cycle).

Verification
REQ-032 Reset release, memory returns 16'hB890 at 0x00000, 16'h0000 at 0x00002 -> q_byte=90, q_ip=0000; then B8, q_ip=0001; o_addr steps 00000, 00002.
REQ-033 flush with i_cs=1234, i_ip=0005 -> o_addr=12344, o_rd=1; i_data=AB_CD pushes only AB with q_ip=0005; next o_addr=12346.
REQ-034 No q_take, memory always ready, DEPTH=6 -> exactly 3 fetches, count=6, o_rd=0; one q_take -> o_rd stays 0 (count 5, even fetch_ip); second q_take -> o_rd=1.
REQ-035 count=1, q_take and m_ready (i_data=2211, even) same cycle -> count=2, q_byte=11, then 22; no byte lost or duplicated.
REQ-036 i_cs=F000, i_ip=FFFE, flush, three fetches -> o_addr FFFFE, F0000 (fetch_ip wrapped to 0000), F0002; q_ip wraps FFFF->0000.
REQ-037 flush asserted in same cycle as m_ready and q_take -> data discarded, count=0, q_ip=i_ip next cycle; locked pulsed low mid-stream -> all REQ-029 values immediately.
